// File: rtl/fpany_normalizer.sv
// fpany_normalizer: three-stage normalizer that turns {sign, exp, two's-complement fixed-point
// mantissa} partial sums into packed {sign, exp, mantissa} floats, with valid/ready backpressure.
// Build option: define FPANY_NORM_RNE_EN for round-to-nearest-even; otherwise the mantissa is
// truncated.
module fpany_normalizer #(
    parameter int unsigned E    = 5,
    parameter int unsigned M    = 10,
    parameter int unsigned INT  = 4,
    parameter int unsigned FRAC = 12
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                clear,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [E+INT+FRAC:0] in_psum,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [E+M:0]        out_fp,
    output logic                ovf_flag,
    output logic                udf_flag
);
    localparam int unsigned PWIDTH = INT + FRAC;
    localparam int unsigned LW     = $clog2(PWIDTH + 1);  // leading-one index width
    localparam int unsigned NW     = E + 3;               // signed exponent working width

    localparam logic [PWIDTH:0]      MagOne = {{PWIDTH{1'b0}}, 1'b1};
    localparam logic signed [NW-1:0] NeFrac = NW'(FRAC);
    localparam logic signed [NW-1:0] NeMax  = NW'((2 ** E) - 1);
    localparam logic [E-1:0]         ExpSat = E'((2 ** E) - 2);
`ifdef FPANY_NORM_RNE_EN
    localparam logic signed [NW-1:0] NeOne  = {{(NW-1){1'b0}}, 1'b1};
`endif

    // Handshake / stage control
    logic s1_adv, s2_adv, s3_adv;
    logic s1_load, s2_load, s3_load;
    logic s1_valid_q, s1_valid_d;
    logic s2_valid_q, s2_valid_d;
    logic out_valid_q, out_valid_d;

    // S1: magnitude
    logic              s1_sign_q, s1_sign_d;
    logic [E-1:0]      s1_exp_q, s1_exp_d;
    logic [PWIDTH:0]   s1_mag_q, s1_mag_d;
    logic              s1_zero_q, s1_zero_d;
    logic [PWIDTH:0]   s1_raw;

    // S2: leading-one alignment
    logic              s2_sign_q, s2_sign_d;
    logic [E-1:0]      s2_exp_q, s2_exp_d;
    logic              s2_zero_q, s2_zero_d;
    logic [LW-1:0]     s2_lead_q, s2_lead_d;
    logic [M-1:0]      s2_man_q, s2_man_d;
    logic [LW-1:0]     lead;
    logic [PWIDTH:0]   aligned;
`ifdef FPANY_NORM_RNE_EN
    logic              s2_guard_q, s2_guard_d;
    logic              s2_sticky_q, s2_sticky_d;
    logic              round_inc;
    logic [M:0]        man_rnd;
    logic              unused_aligned;
    // The hidden bit is implied by the exponent and never stored.
    assign unused_aligned = aligned[PWIDTH];
`else
    logic              unused_aligned;
    // Hidden bit and the bits below the kept mantissa are dropped when truncating.
    assign unused_aligned = ^{aligned[PWIDTH], aligned[PWIDTH-1-M:0]};
`endif

    // S3: exponent adjust, round, saturate/flush
    logic signed [NW-1:0] ne;
    logic [M-1:0]         man_f;
    logic [E+M:0]         res;
    logic                 ovf_hit, udf_hit;
    logic [E+M:0]         out_fp_q, out_fp_d;
    logic                 ovf_flag_q, ovf_flag_d;
    logic                 udf_flag_q, udf_flag_d;

    // Backpressure chain: a stage moves when it is empty or its successor moves.
    always_comb begin
        s3_adv   = !out_valid_q || out_ready;
        s2_adv   = !s2_valid_q || s3_adv;
        s1_adv   = !s1_valid_q || s2_adv;
        in_ready = !clear && s1_adv;
        s1_load  = in_valid && in_ready;
        s2_load  = !clear && s2_adv && s1_valid_q;
        s3_load  = !clear && s3_adv && s2_valid_q;

        s1_valid_d  = clear ? 1'b0 : (s1_adv ? in_valid : s1_valid_q);
        s2_valid_d  = clear ? 1'b0 : (s2_adv ? s1_valid_q : s2_valid_q);
        out_valid_d = clear ? 1'b0 : (s3_adv ? s2_valid_q : out_valid_q);
    end

    // S1 next state: unpack and take the absolute value (PWIDTH+1 bits holds -2^PWIDTH).
    always_comb begin
        s1_raw    = {in_psum[E+PWIDTH], in_psum[PWIDTH-1:0]};
        s1_sign_d = s1_sign_q;
        s1_exp_d  = s1_exp_q;
        s1_mag_d  = s1_mag_q;
        s1_zero_d = s1_zero_q;
        if (s1_load) begin
            s1_sign_d = s1_raw[PWIDTH];
            s1_exp_d  = in_psum[E+PWIDTH-1 -: E];
            s1_mag_d  = s1_raw[PWIDTH] ? ((~s1_raw) + MagOne) : s1_raw;
            s1_zero_d = (s1_raw == '0);
        end
    end

    // S2 next state: find the leading one and left-align it onto the hidden-bit position.
    always_comb begin
        lead = '0;
        for (int unsigned i = 0; i <= PWIDTH; i++) begin
            if (s1_mag_q[i]) lead = LW'(i);
        end
        aligned = s1_mag_q << (LW'(PWIDTH) - lead);

        s2_sign_d = s2_sign_q;
        s2_exp_d  = s2_exp_q;
        s2_zero_d = s2_zero_q;
        s2_lead_d = s2_lead_q;
        s2_man_d  = s2_man_q;
`ifdef FPANY_NORM_RNE_EN
        s2_guard_d  = s2_guard_q;
        s2_sticky_d = s2_sticky_q;
`endif
        if (s2_load) begin
            s2_sign_d = s1_sign_q;
            s2_exp_d  = s1_exp_q;
            s2_zero_d = s1_zero_q;
            s2_lead_d = lead;
            s2_man_d  = aligned[PWIDTH-1 -: M];
`ifdef FPANY_NORM_RNE_EN
            s2_guard_d  = aligned[PWIDTH-1-M];
            s2_sticky_d = |aligned[PWIDTH-2-M:0];
`endif
        end
    end

    // S3 datapath: rebias by the leading-one position, round, then saturate or flush.
    always_comb begin
        ne = $signed(NW'(s2_exp_q)) + $signed(NW'(s2_lead_q)) - NeFrac;
`ifdef FPANY_NORM_RNE_EN
        round_inc = s2_guard_q && (s2_sticky_q || s2_man_q[0]);
        man_rnd   = {1'b0, s2_man_q} + {{M{1'b0}}, round_inc};
        // Carry-out leaves the low bits at zero; bump the exponent instead.
        if (man_rnd[M]) ne = ne + NeOne;
        man_f = man_rnd[M-1:0];
`else
        man_f = s2_man_q;
`endif
        ovf_hit = 1'b0;
        udf_hit = 1'b0;
        res     = {s2_sign_q, ne[E-1:0], man_f};
        if (s2_zero_q) begin
            res = '0;
        end else if (ne >= NeMax) begin
            res     = {s2_sign_q, ExpSat, {M{1'b1}}};
            ovf_hit = 1'b1;
        end else if (ne[NW-1] || (ne == '0)) begin
            res     = '0;
            udf_hit = 1'b1;
        end
    end

    // Output register and sticky flags; flags latch as the result enters the output stage.
    always_comb begin
        out_fp_d   = out_fp_q;
        ovf_flag_d = ovf_flag_q;
        udf_flag_d = udf_flag_q;
        if (s3_load) begin
            out_fp_d   = res;
            ovf_flag_d = ovf_flag_q | ovf_hit;
            udf_flag_d = udf_flag_q | udf_hit;
        end
        if (clear) begin
            ovf_flag_d = 1'b0;
            udf_flag_d = 1'b0;
        end
    end

    // All pipeline state, asynchronously cleared.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_mag_q    <= '0;
            s1_zero_q   <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_zero_q   <= 1'b0;
            s2_lead_q   <= '0;
            s2_man_q    <= '0;
`ifdef FPANY_NORM_RNE_EN
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
`endif
            out_fp_q    <= '0;
            ovf_flag_q  <= 1'b0;
            udf_flag_q  <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_valid_q <= out_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_exp_q    <= s1_exp_d;
            s1_mag_q    <= s1_mag_d;
            s1_zero_q   <= s1_zero_d;
            s2_sign_q   <= s2_sign_d;
            s2_exp_q    <= s2_exp_d;
            s2_zero_q   <= s2_zero_d;
            s2_lead_q   <= s2_lead_d;
            s2_man_q    <= s2_man_d;
`ifdef FPANY_NORM_RNE_EN
            s2_guard_q  <= s2_guard_d;
            s2_sticky_q <= s2_sticky_d;
`endif
            out_fp_q    <= out_fp_d;
            ovf_flag_q  <= ovf_flag_d;
            udf_flag_q  <= udf_flag_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_fp    = out_fp_q;
    assign ovf_flag  = ovf_flag_q;
    assign udf_flag  = udf_flag_q;

endmodule

// File: tb/tb_fpany_normalizer.sv
// tb_fpany_normalizer: directed vectors, backpressure/clear/reset sequences and a randomized
// scoreboard run against an arithmetic reference model of the normalizer.
module tb_fpany_normalizer;
    localparam int E      = 5;
    localparam int M      = 10;
    localparam int INT    = 4;
    localparam int FRAC   = 12;
    localparam int PWIDTH = INT + FRAC;
    localparam int PSW    = E + PWIDTH + 1;
    localparam int FW     = E + M + 1;

`ifdef FPANY_NORM_RNE_EN
    localparam logic [FW-1:0] Exp1006 = 16'h3C02;
    localparam logic [FW-1:0] Exp1FFF = 16'h4000;
`else
    localparam logic [FW-1:0] Exp1006 = 16'h3C01;
    localparam logic [FW-1:0] Exp1FFF = 16'h3FFF;
`endif

    logic           clock     = 1'b0;
    logic           resetn    = 1'b0;
    logic           clear     = 1'b0;
    logic           in_valid  = 1'b0;
    logic           out_ready = 1'b1;
    logic [PSW-1:0] in_psum   = '0;
    logic           in_ready, out_valid, ovf_flag, udf_flag;
    logic [FW-1:0]  out_fp;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string          name;
        logic [PSW-1:0] psum;
        logic [FW-1:0]  fp;
        logic           ovf;
        logic           udf;
    } vec_t;

    fpany_normalizer #(.E(E), .M(M), .INT(INT), .FRAC(FRAC)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_psum   (in_psum),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_fp    (out_fp),
        .ovf_flag  (ovf_flag),
        .udf_flag  (udf_flag)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, req);
        end
    endtask

    function automatic logic [PSW-1:0] mk(input logic s, input int e, input int m);
        return {s, E'(e), PWIDTH'(m)};
    endfunction

    // Reference: exact value -> nearest representable by plain integer arithmetic.
    function automatic logic [FW-1:0] model(input logic [PSW-1:0] p, output logic ovf,
                                            output logic udf);
        longint v, mag, q, rem, half;
        int     pw, ne;
        logic   s;
        s   = p[PSW-1];
        v   = longint'(p[PWIDTH-1:0]) - (s ? (longint'(1) << PWIDTH) : longint'(0));
        mag = (v < 0) ? -v : v;
        ovf = 1'b0;
        udf = 1'b0;
        if (mag == 0) return '0;
        pw = 0;
        while ((longint'(1) << (pw + 1)) <= mag) pw++;
        ne  = int'(p[PSW-2 -: E]) + pw - FRAC;
        q   = (mag << M) >> pw;
        rem = (mag << M) - (q << pw);
`ifdef FPANY_NORM_RNE_EN
        if (pw > 0) begin
            half = longint'(1) << (pw - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == (longint'(1) << (M + 1))) begin
            q = q >> 1;
            ne++;
        end
`else
        half = rem;
`endif
        if (ne >= (1 << E) - 1) begin
            ovf = 1'b1;
            return {s, E'((1 << E) - 2), {M{1'b1}}};
        end
        if (ne <= 0) begin
            udf = 1'b1;
            return '0;
        end
        return {s, ne[E-1:0], q[M-1:0]};
    endfunction

    task automatic clear_pulse();
        @(negedge clock);
        in_valid = 1'b0;
        clear    = 1'b1;
        @(negedge clock);
        clear = 1'b0;
    endtask

    // One transaction on an idle pipeline; lat counts edges from acceptance to out_valid.
    task automatic single(input logic [PSW-1:0] p, output logic [FW-1:0] fp, output int lat);
        @(negedge clock);
        in_psum   = p;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clock);
            #1 lat++;
        end
        fp = out_fp;
    endtask

    // Load three entries with the output stalled; the first overflows.
    task automatic fill3();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_psum  = (k == 0) ? mk(1'b0, 30, 'h8000) : mk(1'b0, 15, 'h1000 + k);
        end
        @(negedge clock);
        in_valid = 1'b0;
    endtask

    initial begin
        vec_t           vecs[$];
        logic [FW-1:0]  fp, efp;
        logic [FW-1:0]  expq[$];
        logic [PSW-1:0] bp[8];
        logic           o, u, eo, eu, in_fire, out_fire;
        int             lat, extra, idx, got, cyc, stale;

        vecs.push_back('{"one",      mk(1'b0, 15, 'h1000), 16'h3C00, 1'b0, 1'b0});
        vecs.push_back('{"neg_one",  mk(1'b1, 15, 'hF000), 16'hBC00, 1'b0, 1'b0});
        vecs.push_back('{"two",      mk(1'b0, 15, 'h2000), 16'h4000, 1'b0, 1'b0});
        vecs.push_back('{"rnd1006",  mk(1'b0, 15, 'h1006), Exp1006,  1'b0, 1'b0});
        vecs.push_back('{"tie1002",  mk(1'b0, 15, 'h1002), 16'h3C00, 1'b0, 1'b0});
        vecs.push_back('{"carry",    mk(1'b0, 15, 'h1FFF), Exp1FFF,  1'b0, 1'b0});
        vecs.push_back('{"ovf",      mk(1'b0, 30, 'h8000), 16'h7BFF, 1'b1, 1'b0});
        vecs.push_back('{"udf",      mk(1'b1, 1,  'hFFFF), 16'h0000, 1'b0, 1'b1});
        vecs.push_back('{"zero",     mk(1'b0, 20, 'h0000), 16'h0000, 1'b0, 1'b0});
        vecs.push_back('{"most_neg", mk(1'b1, 15, 'h0000), 16'hCC00, 1'b0, 1'b0});
        vecs.push_back('{"exp0",     mk(1'b0, 0,  'h8000), 16'h0C00, 1'b0, 1'b0});
        vecs.push_back('{"max_exp",  mk(1'b0, 30, 'h1000), 16'h7800, 1'b0, 1'b0});
        vecs.push_back('{"min_exp",  mk(1'b0, 1,  'h1000), 16'h0400, 1'b0, 1'b0});
        vecs.push_back('{"ne_zero",  mk(1'b0, 0,  'h1000), 16'h0000, 1'b0, 1'b1});

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_fp", 32'(out_fp), 0);
        check("rst_ovf", 32'(ovf_flag), 0);
        check("rst_udf", 32'(udf_flag), 0);
        resetn = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 1);

        // Directed vectors
        foreach (vecs[i]) begin
            clear_pulse();
            single(vecs[i].psum, fp, lat);
            check({vecs[i].name, "_fp"}, 32'(fp), 32'(vecs[i].fp));
            check({vecs[i].name, "_ovf"}, 32'(ovf_flag), 32'(vecs[i].ovf));
            check({vecs[i].name, "_udf"}, 32'(udf_flag), 32'(vecs[i].udf));
            check({vecs[i].name, "_lat"}, 32'(lat), 3);
        end

        // Backpressure: 8 back-to-back psums, output stalled for 6 cycles
        clear_pulse();
        for (int i = 0; i < 8; i++) bp[i] = mk(1'(i & 1), 10 + i, 'h1000 + i * 'h123);
        idx = 0;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 100) begin
            @(negedge clock);
            out_ready = (cyc >= 6);
            in_valid  = (idx < 8);
            in_psum   = (idx < 8) ? bp[idx] : '0;
            #1;
            if (cyc == 3) begin
                check("bp_in_ready_low", 32'(in_ready), 0);
                check("bp_accepted_before_stall", 32'(idx), 3);
            end
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            fp       = out_fp;
            @(posedge clock);
            if (in_fire) idx++;
            if (out_fire) begin
                check("bp_order", 32'(fp), 32'(model(bp[got], o, u)));
                got++;
            end
            cyc++;
        end
        check("bp_count", 32'(got), 8);
        check("bp_accepted", 32'(idx), 8);
        @(negedge clock);
        in_valid = 1'b0;

        // Clear with a full pipeline and a simultaneous input
        clear_pulse();
        fill3();
        #1;
        check("clr_pre_valid", 32'(out_valid), 1);
        check("clr_pre_ovf", 32'(ovf_flag), 1);
        check("clr_pre_in_ready", 32'(in_ready), 0);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_psum  = mk(1'b0, 15, 'h2000);
        #1 check("clr_in_ready", 32'(in_ready), 0);
        @(posedge clock);
        #1;
        check("clr_out_valid", 32'(out_valid), 0);
        check("clr_ovf", 32'(ovf_flag), 0);
        check("clr_udf", 32'(udf_flag), 0);
        @(negedge clock);
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clock);
            #1 if (out_valid) stale++;
        end
        check("clr_no_accept", 32'(stale), 0);
        single(mk(1'b0, 15, 'h2000), fp, lat);
        check("clr_after_fp", 32'(fp), 32'h4000);
        check("clr_after_lat", 32'(lat), 3);

        // Asynchronous reset with three entries in flight
        clear_pulse();
        fill3();
        #1 check("arst_pre_fp", 32'(out_fp), 32'h7BFF);
        #1 resetn = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 0);
        check("arst_out_fp", 32'(out_fp), 0);
        check("arst_ovf", 32'(ovf_flag), 0);
        check("arst_udf", 32'(udf_flag), 0);
        @(negedge clock);
        resetn    = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1 if (out_valid) stale++;
        end
        check("arst_no_stale", 32'(stale), 0);
        single(mk(1'b1, 15, 'hF000), fp, lat);
        check("arst_after_fp", 32'(fp), 32'hBC00);

        // Randomized traffic against the reference model
        clear_pulse();
        eo    = 1'b0;
        eu    = 1'b0;
        extra = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            in_valid  = (c < 300) && ($urandom_range(0, 3) != 0);
            in_psum   = mk(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), int'($urandom));
            out_ready = (c >= 300) || ($urandom_range(0, 3) != 0);
            #1;
            in_fire  = in_valid && in_ready;
            out_fire = out_valid && out_ready;
            fp       = out_fp;
            @(posedge clock);
            if (in_fire) begin
                efp = model(in_psum, o, u);
                expq.push_back(efp);
                eo = eo | o;
                eu = eu | u;
            end
            if (out_fire) begin
                if (expq.size() == 0) extra++;
                else check("rand_fp", 32'(fp), 32'(expq.pop_front()));
            end
        end
        #1;
        check("rand_extra", 32'(extra), 0);
        check("rand_left", 32'(expq.size()), 0);
        check("rand_ovf", 32'(ovf_flag), 32'(eo));
        check("rand_udf", 32'(udf_flag), 32'(eu));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
